// File: rtl/fsm_seq_detector.sv
// Moore detector for the overlapping serial pattern 1-0-0-1.
// The three state flip-flops are exported so lab instrumentation can observe them.
module fsm_seq_detector (
    output logic yO,
    output logic DaO,
    output logic DbO,
    output logic DcO,
    input  logic xin,
    input  logic clock,
    input  logic reset
);

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S0 = 3'b000;  // idle
    localparam logic [STATE_W-1:0] S1 = 3'b001;  // seen "1"
    localparam logic [STATE_W-1:0] S2 = 3'b010;  // seen "10"
    localparam logic [STATE_W-1:0] S3 = 3'b011;  // seen "100"
    localparam logic [STATE_W-1:0] S4 = 3'b100;  // seen "1001"

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               y_q;
    logic               y_d;

    // State register; the detect flag is registered alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    // Next-state logic; unused codes fall back to idle.
    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0:      state_d = xin ? S1 : S0;
            S1:      state_d = xin ? S1 : S2;
            S2:      state_d = xin ? S1 : S3;
            S3:      state_d = xin ? S4 : S0;
            S4:      state_d = xin ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    // Detect flag tracks the state being entered, so y_q equals (state_q == S4).
    always_comb begin
        y_d = 1'b0;
        if (state_d == S4) begin
            y_d = 1'b1;
        end
    end

    assign yO  = y_q;
    assign DaO = state_q[2];
    assign DbO = state_q[1];
    assign DcO = state_q[0];

endmodule

// File: tb/tb_fsm_seq_detector.sv
// Directed bench for fsm_seq_detector: reset, lab stream, overlap, near-miss,
// mid-pattern reset and recovery from unused state codes.
module tb_fsm_seq_detector;

    logic clock;
    logic reset;
    logic xin;
    logic yO;
    logic DaO;
    logic DbO;
    logic DcO;

    int checks;
    int errors;

    fsm_seq_detector dut (
        .yO    (yO),
        .DaO   (DaO),
        .DbO   (DbO),
        .DcO   (DcO),
        .xin   (xin),
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic x);
        @(negedge clock);
        reset = r;
        xin   = x;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] st;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            st = {DaO, DbO, DcO};
            checks++;
            if (st !== 3'b000) begin
                errors++;
                $display("FAIL reset_state edge %0d: got %b expected 000", i, st);
            end
            checks++;
            if (yO !== 1'b0) begin
                errors++;
                $display("FAIL reset_y edge %0d: got %b expected 0", i, yO);
            end
        end
    endtask

    task automatic test_lab_stream();
        logic       bits [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        logic [2:0] exp_st [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                                    3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
        logic [2:0] st;
        logic       exp_y;
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, bits[i]);
            st    = {DaO, DbO, DcO};
            exp_y = (i == 8);
            checks++;
            if (st !== exp_st[i]) begin
                errors++;
                $display("FAIL lab_state bit %0d: got %b expected %b", i, st, exp_st[i]);
            end
            checks++;
            if (yO !== exp_y) begin
                errors++;
                $display("FAIL lab_y bit %0d: got %b expected %b", i, yO, exp_y);
            end
        end
    endtask

    task automatic test_overlap();
        logic       bits [7] = '{1, 0, 0, 1, 0, 0, 1};
        logic [2:0] exp_st [7] = '{3'b001, 3'b010, 3'b011, 3'b100,
                                   3'b010, 3'b011, 3'b100};
        logic [2:0] st;
        logic       exp_y;
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, bits[i]);
            st    = {DaO, DbO, DcO};
            exp_y = (i == 3) || (i == 6);
            checks++;
            if (st !== exp_st[i]) begin
                errors++;
                $display("FAIL overlap_state bit %0d: got %b expected %b", i, st, exp_st[i]);
            end
            checks++;
            if (yO !== exp_y) begin
                errors++;
                $display("FAIL overlap_y bit %0d: got %b expected %b", i, yO, exp_y);
            end
        end
    endtask

    task automatic test_near_miss();
        logic       bits [5] = '{1, 0, 0, 0, 1};
        logic [2:0] exp_st [5] = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b001};
        logic [2:0] st;
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, bits[i]);
            st = {DaO, DbO, DcO};
            checks++;
            if (st !== exp_st[i]) begin
                errors++;
                $display("FAIL near_miss_state bit %0d: got %b expected %b", i, st, exp_st[i]);
            end
            checks++;
            if (yO !== 1'b0) begin
                errors++;
                $display("FAIL near_miss_y bit %0d: got %b expected 0", i, yO);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] st;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        st = {DaO, DbO, DcO};
        checks++;
        if (st !== 3'b011) begin
            errors++;
            $display("FAIL mid_reset_pre: got %b expected 011", st);
        end
        step(1'b1, 1'b1);
        st = {DaO, DbO, DcO};
        checks++;
        if (st !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_state: got %b expected 000", st);
        end
        checks++;
        if (yO !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_y: got %b expected 0", yO);
        end
        step(1'b0, 1'b1);
        st = {DaO, DbO, DcO};
        checks++;
        if (st !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset_release: got %b expected 001", st);
        end
        checks++;
        if (yO !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release_y: got %b expected 0", yO);
        end
    endtask

    task automatic test_illegal_states();
        logic [2:0] codes [3] = '{3'b101, 3'b110, 3'b111};
        logic [2:0] st;
        for (int c = 0; c < 3; c++) begin
            for (int x = 0; x < 2; x++) begin
                step(1'b1, 1'b0);
                @(negedge clock);
                reset         = 1'b0;
                xin           = 1'(x);
                dut.state_q   = codes[c];
                #1;
                st = {DaO, DbO, DcO};
                checks++;
                if (st !== codes[c]) begin
                    errors++;
                    $display("FAIL illegal_deposit code %b x %0d: got %b", codes[c], x, st);
                end
                checks++;
                if (yO !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_y_in code %b x %0d: got %b expected 0", codes[c], x, yO);
                end
                @(posedge clock);
                #1;
                st = {DaO, DbO, DcO};
                checks++;
                if (st !== 3'b000) begin
                    errors++;
                    $display("FAIL illegal_exit code %b x %0d: got %b expected 000", codes[c], x, st);
                end
                checks++;
                if (yO !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_y_out code %b x %0d: got %b expected 0", codes[c], x, yO);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        xin    = 1'b1;
        test_reset();
        test_lab_stream();
        test_overlap();
        test_near_miss();
        test_mid_reset();
        test_illegal_states();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
